ibex_irq_encoder: RTL and testbench

- Interrupt-side counterpart to the core's trap handling.
- Samples platform interrupt lines (software, timer, external, 15 fast, NMI) and applies mie and mstatus.MIE masking.
- Resolves priority and presents a single registered request with an exception-cause code to the controller over a req/ack handshake.
- Sits between top-level irq inputs and the controller. Owns synchronisation, NMI edge capture, cause encoding and request stability.

---
 rtl/ibex_irq_encoder.sv | 195 +++++++++++++++++++
 tb/tb_ibex_irq_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_irq_encoder.sv
// Interrupt request encoder: synchronises irq lines, captures NMI edges,
// masks, prioritises and hands one stable request to the controller.
module ibex_irq_encoder #(
    parameter int unsigned SyncStages = 2,
    parameter bit          NmiEdge    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic [14:0] irq_fast_i,
    input  logic        irq_nm_i,
    input  logic [17:0] csr_mie_i,
    input  logic        csr_mstatus_mie_i,
    input  logic        debug_mode_i,
    output logic        irq_req_o,
    output logic [5:0]  irq_cause_o,
    output logic        irq_nm_o,
    input  logic        irq_ack_i,
    output logic        irq_pending_o,
    output logic [17:0] irqs_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BLANK = 2'd2
    } state_e;

    logic [18:0] raw;
    logic [18:0] synced;
    logic        nmi_sync;

    assign raw = {irq_nm_i, irq_software_i, irq_timer_i,
                  irq_external_i, irq_fast_i};

    generate
        if (SyncStages == 0) begin : g_bypass
            assign synced = raw;
        end else begin : g_sync
            logic [18:0] sync_q [SyncStages];
            logic [18:0] sync_d [SyncStages];

            always_comb begin
                sync_d[0] = raw;
                for (int i = 1; i < int'(SyncStages); i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < int'(SyncStages); i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign synced = sync_q[SyncStages-1];
        end
    endgenerate

    assign irqs_o   = synced[17:0];
    assign nmi_sync = synced[18];

    // NMI edge latch; held until the NMI request itself is acknowledged
    logic nmi_prev_q, nmi_prev_d;
    logic nmi_q, nmi_d;
    logic nmi_clr;
    logic nmi_act;

    always_comb begin
        nmi_prev_d = nmi_sync;
        nmi_d      = (nmi_q & ~nmi_clr) | (nmi_sync & ~nmi_prev_q);
    end

    assign nmi_act = NmiEdge ? nmi_q : nmi_sync;

    logic [17:0] elig;
    logic        nmi_elig;
    logic        gate;

    assign gate     = csr_mstatus_mie_i & ~debug_mode_i;
    assign elig     = irqs_o & csr_mie_i & {18{gate}};
    assign nmi_elig = nmi_act & ~debug_mode_i;

    logic       win_valid;
    logic [5:0] win_cause;
    logic       win_nm;

    always_comb begin
        win_valid = 1'b1;
        win_cause = 6'd0;
        win_nm    = 1'b0;
        if (nmi_elig) begin
            win_cause = 6'h3F;
            win_nm    = 1'b1;
        end else if (|elig[14:0]) begin
            for (int i = 14; i >= 0; i--) begin
                if (elig[i]) begin
                    win_cause = 6'd48 + 6'(i);
                end
            end
        end else if (elig[15]) begin
            win_cause = 6'h2B;
        end else if (elig[17]) begin
            win_cause = 6'h23;
        end else if (elig[16]) begin
            win_cause = 6'h27;
        end else begin
            win_valid = 1'b0;
        end
    end

    state_e     state_q, state_d;
    logic [5:0] cause_q, cause_d;
    logic       nm_q, nm_d;
    logic       cap_elig;

    // Is the source behind the held cause still eligible?
    always_comb begin
        cap_elig = 1'b0;
        if (nm_q) begin
            cap_elig = nmi_elig;
        end else begin
            unique case (cause_q[4:0])
                5'd11:   cap_elig = elig[15];
                5'd3:    cap_elig = elig[17];
                5'd7:    cap_elig = elig[16];
                default: cap_elig = cause_q[4] & elig[cause_q[3:0]];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        nm_d    = nm_q;
        nmi_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                    cause_d = win_cause;
                    nm_d    = win_nm;
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    state_d = BLANK;
                    nmi_clr = nm_q;
                end else if (!cap_elig) begin
                    state_d = IDLE;
                end else if (nmi_elig && !nm_q) begin
                    cause_d = 6'h3F;
                    nm_d    = 1'b1;
                end
            end
            BLANK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cause_q    <= 6'd0;
            nm_q       <= 1'b0;
            nmi_q      <= 1'b0;
            nmi_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            nm_q       <= nm_d;
            nmi_q      <= nmi_d;
            nmi_prev_q <= nmi_prev_d;
        end
    end

    assign irq_req_o     = (state_q == REQ);
    assign irq_cause_o   = cause_q;
    assign irq_nm_o      = nm_q;
    assign irq_pending_o = (|(irqs_o & csr_mie_i)) | nmi_act;

`ifndef SYNTHESIS
    ack_only_in_req: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        irq_ack_i |-> (state_q == REQ)
    );
`endif

endmodule

// File: tb/tb_ibex_irq_encoder.sv
// Randomised and directed bench for ibex_irq_encoder against a
// priority-list reference model.
module tb_ibex_irq_encoder;

    localparam int S = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        irq_software_i = 1'b0;
    logic        irq_timer_i = 1'b0;
    logic        irq_external_i = 1'b0;
    logic [14:0] irq_fast_i = '0;
    logic        irq_nm_i = 1'b0;
    logic [17:0] csr_mie_i = '0;
    logic        csr_mstatus_mie_i = 1'b1;
    logic        debug_mode_i = 1'b0;
    logic        irq_req_o;
    logic [5:0]  irq_cause_o;
    logic        irq_nm_o;
    logic        irq_ack_i = 1'b0;
    logic        irq_pending_o;
    logic [17:0] irqs_o;

    ibex_irq_encoder #(.SyncStages(S), .NmiEdge(1'b1)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .irq_software_i    (irq_software_i),
        .irq_timer_i       (irq_timer_i),
        .irq_external_i    (irq_external_i),
        .irq_fast_i        (irq_fast_i),
        .irq_nm_i          (irq_nm_i),
        .csr_mie_i         (csr_mie_i),
        .csr_mstatus_mie_i (csr_mstatus_mie_i),
        .debug_mode_i      (debug_mode_i),
        .irq_req_o         (irq_req_o),
        .irq_cause_o       (irq_cause_o),
        .irq_nm_o          (irq_nm_o),
        .irq_ack_i         (irq_ack_i),
        .irq_pending_o     (irq_pending_o),
        .irqs_o            (irqs_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: delayed input vectors, NMI latch, and the current request
    // as an index into the priority list (0 = NMI, 1..15 = fast,
    // 16 = external, 17 = software, 18 = timer).
    logic [18:0] m_sync [S];
    logic        m_nmi_prev;
    logic        m_nmi;
    bit          m_req;
    bit          m_blank;
    int          m_src;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] cause_of(int k);
        if (k == 0) return 6'd63;
        if (k <= 15) return 6'(32 + 16 + k - 1);
        if (k == 16) return 6'(32 + 11);
        if (k == 17) return 6'(32 + 3);
        return 6'(32 + 7);
    endfunction

    function automatic bit elig(int k);
        logic [17:0] v;
        int idx;
        v = m_sync[S-1][17:0];
        if (k == 0) return m_nmi & ~debug_mode_i;
        if (k <= 15) idx = k - 1;
        else if (k == 16) idx = 15;
        else if (k == 17) idx = 17;
        else idx = 16;
        return v[idx] & csr_mie_i[idx] & csr_mstatus_mie_i & ~debug_mode_i;
    endfunction

    function automatic int winner();
        for (int k = 0; k <= 18; k++) begin
            if (elig(k)) return k;
        end
        return -1;
    endfunction

    task automatic m_init();
        for (int i = 0; i < S; i++) m_sync[i] = '0;
        m_nmi_prev = 1'b0;
        m_nmi = 1'b0;
        m_req = 1'b0;
        m_blank = 1'b0;
        m_src = -1;
    endtask

    task automatic tick();
        bit n_req, n_blank, clr;
        int n_src, w;
        logic n_nmi, rise;
        n_req = m_req;
        n_blank = 1'b0;
        n_src = m_src;
        clr = 1'b0;
        if (m_blank) begin
            n_req = 1'b0;
        end else if (!m_req) begin
            w = winner();
            if (w >= 0) begin
                n_req = 1'b1;
                n_src = w;
            end
        end else if (irq_ack_i) begin
            n_req = 1'b0;
            n_blank = 1'b1;
            clr = (m_src == 0);
        end else if (!elig(m_src)) begin
            n_req = 1'b0;
        end else if (m_src != 0 && elig(0)) begin
            n_src = 0;
        end
        rise = m_sync[S-1][18] & ~m_nmi_prev;
        n_nmi = (m_nmi & ~clr) | rise;
        @(posedge clk_i);
        m_req = n_req;
        m_blank = n_blank;
        m_src = n_src;
        m_nmi = n_nmi;
        m_nmi_prev = m_sync[S-1][18];
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = {irq_nm_i, irq_software_i, irq_timer_i,
                     irq_external_i, irq_fast_i};
        #1;
    endtask

    task automatic cmp_all();
        logic [17:0] v;
        v = m_sync[S-1][17:0];
        chk("req", irq_req_o, m_req);
        chk("pending", irq_pending_o, (|(v & csr_mie_i)) | m_nmi);
        chk("irqs", irqs_o, v);
        if (m_req) begin
            chk("cause", irq_cause_o, cause_of(m_src));
            chk("nm", irq_nm_o, m_src == 0);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cmp_all();
        end
    endtask

    task automatic wait_req(string tag, int max);
        int n = 0;
        while (!irq_req_o && n < max) begin
            tick();
            cmp_all();
            n++;
        end
        chk(tag, irq_req_o, 1);
    endtask

    task automatic ack_once();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        cmp_all();
    endtask

    task automatic clear_inputs();
        irq_software_i = 1'b0;
        irq_timer_i = 1'b0;
        irq_external_i = 1'b0;
        irq_fast_i = '0;
        irq_nm_i = 1'b0;
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_req"}, irq_req_o, 0);
        chk({tag, "_cause"}, irq_cause_o, 0);
        chk({tag, "_nm"}, irq_nm_o, 0);
        chk({tag, "_pend"}, irq_pending_o, 0);
        chk({tag, "_irqs"}, irqs_o, 0);
    endtask

    initial begin
        int n;
        m_init();
        #1;
        check_zero("rst");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        run(2);

        // Timer: 3-cycle latency, blank after ack, re-request
        csr_mie_i = 18'h10000;
        irq_timer_i = 1'b1;
        run(2);
        chk("tmr_lat2", irq_req_o, 0);
        run(1);
        chk("tmr_lat3", irq_req_o, 1);
        chk("tmr_cause", irq_cause_o, 6'h27);
        ack_once();
        chk("tmr_blank", irq_req_o, 0);
        wait_req("tmr_rereq", 3);
        chk("tmr_cause2", irq_cause_o, 6'h27);
        irq_timer_i = 1'b0;
        run(5);

        // fast3 beats external and software; then external follows
        csr_mie_i = 18'h3FFFF;
        irq_fast_i[3] = 1'b1;
        irq_external_i = 1'b1;
        irq_software_i = 1'b1;
        wait_req("f3_req", 5);
        chk("f3_cause", irq_cause_o, 6'h33);
        irq_fast_i[3] = 1'b0;
        ack_once();
        wait_req("ext_req", 4);
        chk("ext_cause", irq_cause_o, 6'h2B);
        clear_inputs();
        run(5);

        // NMI pulse preempts a software request in place
        irq_software_i = 1'b1;
        wait_req("sw_req", 5);
        chk("sw_cause", irq_cause_o, 6'h23);
        irq_nm_i = 1'b1;
        tick();
        cmp_all();
        irq_nm_i = 1'b0;
        n = 0;
        while (!irq_nm_o && n < 8) begin
            tick();
            cmp_all();
            n++;
        end
        chk("nmi_pre_nm", irq_nm_o, 1);
        chk("nmi_pre_cause", irq_cause_o, 6'h3F);
        chk("nmi_pre_req", irq_req_o, 1);
        ack_once();
        wait_req("sw_after", 4);
        chk("sw_after_cause", irq_cause_o, 6'h23);
        chk("sw_after_nm", irq_nm_o, 0);
        clear_inputs();
        run(5);

        // Global disable withdraws the request, pending stays
        irq_timer_i = 1'b1;
        wait_req("mie_req", 5);
        csr_mstatus_mie_i = 1'b0;
        tick();
        cmp_all();
        chk("mie_drop", irq_req_o, 0);
        chk("mie_pend", irq_pending_o, 1);
        csr_mstatus_mie_i = 1'b1;
        irq_timer_i = 1'b0;
        run(5);

        // Debug mode blocks requests; NMI goes first afterwards
        debug_mode_i = 1'b1;
        irq_external_i = 1'b1;
        irq_nm_i = 1'b1;
        tick();
        cmp_all();
        irq_nm_i = 1'b0;
        run(6);
        chk("dbg_req", irq_req_o, 0);
        chk("dbg_pend", irq_pending_o, 1);
        debug_mode_i = 1'b0;
        wait_req("dbg_nmi_req", 3);
        chk("dbg_nmi_nm", irq_nm_o, 1);
        chk("dbg_nmi_cause", irq_cause_o, 6'h3F);

        // Reset mid-request drops the NMI latch
        irq_external_i = 1'b0;
        rst_ni = 1'b0;
        m_init();
        #1;
        check_zero("mid_rst");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        run(8);
        chk("post_rst_req", irq_req_o, 0);
        irq_nm_i = 1'b1;
        tick();
        cmp_all();
        irq_nm_i = 1'b0;
        wait_req("fresh_nmi", 6);
        chk("fresh_nmi_nm", irq_nm_o, 1);
        ack_once();
        run(3);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 18))
                    15: irq_external_i = ~irq_external_i;
                    16: irq_timer_i = ~irq_timer_i;
                    17: irq_software_i = ~irq_software_i;
                    18: irq_nm_i = ~irq_nm_i;
                    default: irq_fast_i[$urandom_range(0, 14)] ^= 1'b1;
                endcase
            end
            if ($urandom_range(0, 63) == 0) csr_mie_i = 18'($urandom);
            if ($urandom_range(0, 31) == 0) csr_mstatus_mie_i ^= 1'b1;
            if ($urandom_range(0, 63) == 0) debug_mode_i ^= 1'b1;
            irq_ack_i = m_req && ($urandom_range(0, 3) == 0);
            tick();
            irq_ack_i = 1'b0;
            cmp_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
